// File: rtl/dpll_wb_csr_if.sv
// Wishbone classic bus between the management SoC and the DPLL register block.
// Signal names keep the user-area wrapper's wbs_* spelling.
// Backpressure is ack-based only: the initiator holds stb/cyc until ack.
interface dpll_wb_csr_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/dpll_wb_csr.sv
// DPLL control/status registers plus a gated clk_fin edge counter on Wishbone.
// Latency: every request acked one cycle later; done arrives GATE+1 cycles after start ack.
// Backpressure: none beyond ack; ack drops for a cycle between back-to-back requests.
module dpll_wb_csr #(
    parameter logic [31:0]       BASE_ADR = 32'h3000_0000,
    parameter int                GATE_W   = 16,
    parameter int                CNT_W    = 24,
    parameter logic [GATE_W-1:0] GATE_RST = GATE_W'(1000)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    dpll_wb_csr_if.slave        wbs,
    input  logic                clk_fin,
    input  logic [1:0]          freq_select_pad,
    output logic [1:0]          freq_select_o,
    output logic                irq_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [1:0]         sw_sel_q;
    logic               override_q;
    logic               irq_en_q;
    logic               start_q;
    logic [GATE_W-1:0]  gate_q;
    logic [GATE_W-1:0]  timer_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   count_q;
    logic               done_q;
    logic               busy_q;
    logic               ovf_q;
    logic               s1_q, s2_q, s3_q;
    logic               fin_edge;

    logic               req;
    logic               hit;
    logic               wr;
    logic [1:0]         idx;
    logic [31:0]        wmask;
    logic [31:0]        gate_nxt32;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign req   = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~wbs.wbs_ack_o;
    assign hit   = (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign wr    = req & wbs.wbs_we_i & hit;
    assign idx   = wbs.wbs_adr_i[3:2];
    assign wmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
    assign gate_nxt32  = (32'(gate_q) & ~wmask) | (wbs.wbs_dat_i & wmask);
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], gate_nxt32};

    assign freq_select_o = override_q ? sw_sel_q : freq_select_pad;
    assign irq_o         = done_q & irq_en_q;
    assign fin_edge      = s2_q & ~s3_q;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                2'd0:    rdata = {27'd0, irq_en_q, 1'b0, override_q, sw_sel_q};
                2'd1:    rdata = 32'(gate_q);
                2'd2:    rdata = 32'(count_q);
                default: rdata = {29'd0, ovf_q, busy_q, done_q};
            endcase
        end
    end

    // Saturating edge counter; the wrap case is what flags ovf.
    always_comb begin
        cnt_nxt = cnt_q;
        if (fin_edge && !(&cnt_q))
            cnt_nxt = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= req;
            wbs.wbs_dat_o <= (req && !wbs.wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sw_sel_q   <= 2'd0;
            override_q <= 1'b0;
            irq_en_q   <= 1'b0;
            start_q    <= 1'b0;
            gate_q     <= GATE_RST;
        end else begin
            start_q <= wr && (idx == 2'd0) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[3];
            if (wr && (idx == 2'd0) && wbs.wbs_sel_i[0]) begin
                sw_sel_q   <= wbs.wbs_dat_i[1:0];
                override_q <= wbs.wbs_dat_i[2];
                irq_en_q   <= wbs.wbs_dat_i[4];
            end
            if (wr && (idx == 2'd1))
                gate_q <= gate_nxt32[GATE_W-1:0];
        end
    end

    // s3 only exists to give a one-cycle-wide rising-edge pulse from s2.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_fin;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // Clears come first so an FSM set in the same cycle overrides them.
            if (wr && (idx == 2'd3) && wbs.wbs_sel_i[0]) begin
                if (wbs.wbs_dat_i[0]) done_q <= 1'b0;
                if (wbs.wbs_dat_i[2]) ovf_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_q) begin
                        timer_q <= gate_q;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        if (gate_q == '0) begin
                            count_q <= '0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fin_edge && (&cnt_q))
                        ovf_q <= 1'b1;
                    if (timer_q == GATE_W'(1)) begin
                        count_q <= cnt_nxt;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q - GATE_W'(1);
                        cnt_q   <= cnt_nxt;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpll_wb_csr.sv
// Bench for dpll_wb_csr: two instances (CNT_W=24 and CNT_W=4) share clock, reset and clk_fin.
// Read expectations go through a queue: pushed when the request is driven, popped on ack.
module tb_dpll_wb_csr;

    localparam logic [31:0] A_CTRL  = 32'h3000_0000;
    localparam logic [31:0] A_GATE  = 32'h3000_0004;
    localparam logic [31:0] A_COUNT = 32'h3000_0008;
    localparam logic [31:0] A_STAT  = 32'h3000_000C;
    localparam logic [31:0] A_OUT   = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_fin = 1'b0;
    logic [1:0]  pad = 2'b11;
    int          fin_half = 0;
    int unsigned cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    logic        stb [2];
    logic        cyc [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic [31:0] wdat[2];
    logic [31:0] adr [2];
    logic        ack_w [2];
    logic [31:0] rd_w  [2];
    logic        irq_w [2];
    logic [1:0]  fso_w [2];

    dpll_wb_csr_if bus0();
    dpll_wb_csr_if bus1();

    assign bus0.wbs_stb_i = stb[0];
    assign bus0.wbs_cyc_i = cyc[0];
    assign bus0.wbs_we_i  = we[0];
    assign bus0.wbs_sel_i = sel[0];
    assign bus0.wbs_dat_i = wdat[0];
    assign bus0.wbs_adr_i = adr[0];
    assign bus1.wbs_stb_i = stb[1];
    assign bus1.wbs_cyc_i = cyc[1];
    assign bus1.wbs_we_i  = we[1];
    assign bus1.wbs_sel_i = sel[1];
    assign bus1.wbs_dat_i = wdat[1];
    assign bus1.wbs_adr_i = adr[1];
    assign ack_w[0] = bus0.wbs_ack_o;
    assign ack_w[1] = bus1.wbs_ack_o;
    assign rd_w[0]  = bus0.wbs_dat_o;
    assign rd_w[1]  = bus1.wbs_dat_o;

    dpll_wb_csr #(.CNT_W(24)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0.slave), .clk_fin(clk_fin),
        .freq_select_pad(pad), .freq_select_o(fso_w[0]), .irq_o(irq_w[0])
    );

    dpll_wb_csr #(.CNT_W(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1.slave), .clk_fin(clk_fin),
        .freq_select_pad(pad), .freq_select_o(fso_w[1]), .irq_o(irq_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // clk_fin transitions land on times ending in 3, never on a wb clock edge.
    initial begin
        #3;
        forever begin
            if (fin_half == 0) #10;
            else begin
                #(fin_half);
                clk_fin = ~clk_fin;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wb_xfer(input int b, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r, output int lat);
        @(posedge clk); #1;
        stb[b] = 1'b1; cyc[b] = 1'b1; we[b] = w; adr[b] = a; wdat[b] = d; sel[b] = s;
        lat = 0;
        r   = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (ack_w[b]) begin
                lat = i;
                break;
            end
        end
        r = rd_w[b];
        stb[b] = 1'b0; cyc[b] = 1'b0; we[b] = 1'b0;
        if (lat == 0) begin
            n_checks++; n_fail++;
            $display("FAIL bus_timeout: bus %0d addr %h got no ack, want ack within 16 cycles", b, a);
        end
    endtask

    task automatic wb_wr(input int b, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        wb_xfer(b, 1'b1, a, d, 4'hF, r, lat);
    endtask

    task automatic wait_irq(input int b, input int unsigned t0, input int budget, output int dt);
        dt = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (irq_w[b]) begin
                dt = int'(cyc_cnt - t0);
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] adrs [4];
        logic [31:0] exps [4];
        logic [31:0] r, e;
        int lat;
        adrs = '{A_CTRL, A_GATE, A_COUNT, A_STAT};
        exps = '{32'h0, 32'd1000, 32'h0, 32'h0};
        n_checks++;
        if (ack_w[0] !== 1'b0 || rd_w[0] !== 32'h0 || irq_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b, want 0/0/0", ack_w[0], rd_w[0], irq_w[0]);
        end
        n_checks++;
        if (fso_w[0] !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_fso: got %b, want 11", fso_w[0]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            wb_xfer(0, 1'b0, adrs[i], 32'h0, 4'hF, r, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h, want %h", i, r, e);
            end
            n_checks++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL reset_ack_latency[%0d]: got %0d, want 1", i, lat);
            end
        end
    endtask

    task automatic test_freq_select;
        logic [31:0] r, e;
        int lat;
        pad = 2'b10;
        #1;
        n_checks++;
        if (fso_w[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL fso_pad: got %b, want 10", fso_w[0]);
        end
        wb_wr(0, A_CTRL, 32'h5);
        n_checks++;
        if (fso_w[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL fso_override: got %b, want 01", fso_w[0]);
        end
        wb_xfer(0, 1'b1, A_CTRL, 32'h0, 4'b0010, r, lat);
        n_checks++;
        if (fso_w[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL fso_sel_masked: got %b, want 01", fso_w[0]);
        end
        exp_q.push_back(32'h5);
        wb_xfer(0, 1'b0, A_CTRL, 32'h0, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL ctrl_sel_masked: got %h, want %h", r, e);
        end
        wb_wr(0, A_CTRL, 32'h0);
        n_checks++;
        if (fso_w[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL fso_release: got %b, want 10", fso_w[0]);
        end
    endtask

    task automatic test_measure;
        logic [31:0] r, e;
        int lat, dt;
        int unsigned t0;
        logic irq_seen;
        fin_half = 50;
        wb_wr(0, A_GATE, 32'd100);
        wb_wr(0, A_CTRL, 32'h08);
        t0 = cyc_cnt;
        exp_q.push_back(32'h2);
        wb_xfer(0, 1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL status_busy: got %h, want %h", r, e);
        end
        irq_seen = 1'b0;
        while (cyc_cnt - t0 < 110) begin
            @(posedge clk); #1;
            if (irq_w[0]) irq_seen = 1'b1;
        end
        n_checks++;
        if (irq_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_masked: got %b, want 0", irq_seen);
        end
        exp_q.push_back(32'h1);
        wb_xfer(0, 1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL status_done: got %h, want %h", r, e);
        end
        wb_xfer(0, 1'b0, A_COUNT, 32'h0, 4'hF, r, lat);
        n_checks++;
        if (r < 32'd9 || r > 32'd11) begin
            n_fail++;
            $display("FAIL count_div10: got %0d, want 9..11", r);
        end
        wb_wr(0, A_CTRL, 32'h10);
        n_checks++;
        if (irq_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_enabled: got %b, want 1", irq_w[0]);
        end
        wb_wr(0, A_STAT, 32'h1);
        n_checks++;
        if (irq_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_w1c: got %b, want 0", irq_w[0]);
        end
        exp_q.push_back(32'h0);
        wb_xfer(0, 1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL status_w1c: got %h, want %h", r, e);
        end
        wb_wr(0, A_CTRL, 32'h18);
        t0 = cyc_cnt;
        wait_irq(0, t0, 300, dt);
        n_checks++;
        if (dt !== 101) begin
            n_fail++;
            $display("FAIL done_latency: got %0d, want 101", dt);
        end
    endtask

    task automatic test_start_busy;
        logic [31:0] r, e;
        int lat, dt;
        int unsigned t0;
        wb_wr(0, A_STAT, 32'h1);
        wb_wr(0, A_CTRL, 32'h18);
        t0 = cyc_cnt;
        exp_q.push_back(32'h2);
        wb_xfer(0, 1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL busy_second_run: got %h, want %h", r, e);
        end
        wb_xfer(0, 1'b0, A_COUNT, 32'h0, 4'hF, r, lat);
        n_checks++;
        if (r < 32'd9 || r > 32'd11) begin
            n_fail++;
            $display("FAIL count_held_while_busy: got %0d, want 9..11", r);
        end
        repeat (20) @(posedge clk);
        wb_wr(0, A_CTRL, 32'h18);
        wait_irq(0, t0, 300, dt);
        n_checks++;
        if (dt !== 101) begin
            n_fail++;
            $display("FAIL start_ignored_latency: got %0d, want 101", dt);
        end
        exp_q.push_back(32'h1);
        wb_xfer(0, 1'b0, A_STAT, 32'h0, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (r !== e) begin
            n_fail++;
            $display("FAIL status_after_ignored_start: got %h, want %h", r, e);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r, e;
        logic [31:0] adrs [4];
        logic [31:0] exps [4];
        int lat, dt;
        int unsigned t0;
        fin_half = 20;
        wb_wr(1, A_GATE, 32'd200);
        wb_wr(1, A_CTRL, 32'h18);
        t0 = cyc_cnt;
        wait_irq(1, t0, 400, dt);
        n_checks++;
        if (dt !== 201) begin
            n_fail++;
            $display("FAIL ovf_latency: got %0d, want 201", dt);
        end
        wb_wr(1, A_GATE, 32'd0);
        adrs = '{A_COUNT, A_STAT, A_COUNT, A_STAT};
        exps = '{32'd15, 32'h5, 32'd0, 32'h1};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exps[i]);
            wb_xfer(1, 1'b0, adrs[i], 32'h0, 4'hF, r, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL ovf_read[%0d]: got %h, want %h", i, r, e);
            end
        end
        wb_wr(1, A_STAT, 32'h5);
        wb_wr(1, A_CTRL, 32'h18);
        t0 = cyc_cnt;
        wait_irq(1, t0, 50, dt);
        n_checks++;
        if (dt !== 1) begin
            n_fail++;
            $display("FAIL gate0_latency: got %0d, want 1", dt);
        end
        for (int i = 2; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            wb_xfer(1, 1'b0, adrs[i], 32'h0, 4'hF, r, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL gate0_read[%0d]: got %h, want %h", i, r, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r, e;
        logic [31:0] adrs [5];
        logic [31:0] exps [5];
        int lat;
        logic irq_seen;
        fin_half = 50;
        wb_wr(0, A_STAT, 32'h5);
        wb_wr(0, A_GATE, 32'd100);
        wb_wr(0, A_CTRL, 32'h18);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        irq_seen = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            if (irq_w[0]) irq_seen = 1'b1;
        end
        n_checks++;
        if (irq_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_reset: got %b, want 0", irq_seen);
        end
        wb_wr(0, A_OUT, 32'hFFFF_FFFF);
        adrs = '{A_STAT, A_COUNT, A_OUT, A_CTRL, A_GATE};
        exps = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd1000};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exps[i]);
            wb_xfer(0, 1'b0, adrs[i], 32'h0, 4'hF, r, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (r !== e || lat !== 1) begin
                n_fail++;
                $display("FAIL post_reset_read[%0d]: got %h lat %0d, want %h lat 1", i, r, lat, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        logic exp_ack;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd1000);
        @(posedge clk); #1;
        stb[0] = 1'b1; cyc[0] = 1'b1; we[0] = 1'b0; adr[0] = A_GATE; sel[0] = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            exp_ack = (i % 2) == 1;
            n_checks++;
            if (ack_w[0] !== exp_ack) begin
                n_fail++;
                $display("FAIL b2b_ack[%0d]: got %b, want %b", i, ack_w[0], exp_ack);
            end
            if (ack_w[0] && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rd_w[0] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h, want %h", i, rd_w[0], e);
                end
            end
        end
        stb[0] = 1'b0; cyc[0] = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            stb[b] = 1'b0; cyc[b] = 1'b0; we[b] = 1'b0;
            sel[b] = 4'h0; wdat[b] = 32'h0; adr[b] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_freq_select();
        test_measure();
        test_start_busy();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
